axil_ram_port: RTL
==================

Name: axil_ram_port

Overview:
- AXI4-Lite slave that acts as initiator on a single byte-enabled block-RAM port: en, addr, write data, byte strobes, and registered read data one cycle after en.
- Connects one port of the team's dual-port byte-enable RAM to an AXI4-Lite interconnect, giving the CPU access to a shared buffer.
- One transaction is in flight at a time; reads and writes are arbitrated round-robin.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, data width; must be 32 or 64.
- AXIL_ADDR_W, 32, AXI byte-address width; must be ≥ ADDR_W+log2(DATA_W/8).

Ports:
clk  in  1  clock; the only clock
rst  in  1  reset, synchronous, active-high
awValid/awReady  in/out  1  write-address handshake
awAddr  in  AXIL_ADDR_W  write byte address
wValid/wReady  in/out  1  write-data handshake
wData  in  DATA_W  write data
wStrb  in  DATA_W/8  byte strobes
bValid/bReady  out/in  1  write-response handshake
bResp  out  2  00 OKAY, 10 SLVERR
arValid/arReady  in/out  1  read-address handshake
arAddr  in  AXIL_ADDR_W  read byte address
rValid/rReady  out/in  1  read-data handshake
rData  out  DATA_W  read data
rResp  out  2  00 OKAY, 10 SLVERR
ramAddr  out  ADDR_W  RAM word address
ramWrite  out  DATA_W  RAM write data
ramStrb  out  DATA_W/8  RAM byte strobes; all zero means read-only access
ramEn  out  1  RAM port enable
ramRead  in  DATA_W  RAM read data, valid the cycle after ramEn

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all ready/valid outputs 0; ramEn=0; ramAddr, ramWrite, ramStrb, rData, bResp, rResp all 0; lastGrantWrite=0.
  - A transaction in progress is dropped with no response; a RAM write already issued stays issued.
- Word index = byte address bits [S+ADDR_W-1:S], where S=log2(DATA_W/8).
  - Low S bits are ignored.
  - Any set bit above S+ADDR_W-1 makes the address out-of-range (OOR).
- Write acceptance:
  - awReady=wReady=1 only in IDLE, only when awValid&&wValid, and only when write is granted.
  - AW and W are always accepted in the same cycle; a lone AW or lone W waits.
- Arbitration in IDLE:
  - Only one side pending: that side is granted.
  - Both pending: write wins if lastGrantWrite=0, otherwise read wins.
  - lastGrantWrite updates to the granted type on every grant.
- arReady=1 only in IDLE, only when arValid and read is granted.
- Handshake cycle: latch word index, wData, wStrb and the OOR flag into registers.
- States:
  - IDLE -> W_ISSUE on write handshake; IDLE -> R_ISSUE on read handshake.
  - W_ISSUE (1 cycle): ramEn=!OOR, ramStrb=latched wStrb, ramWrite=latched wData -> W_RESP.
  - W_RESP: bValid=1, bResp=OOR?10:00; bResp stable while bValid; exit to IDLE on bValid&&bReady.
  - R_ISSUE (1 cycle): ramEn=!OOR, ramStrb=0 -> R_CAPT.
  - R_CAPT (1 cycle): rData<=OOR?0:ramRead, rResp<=OOR?10:00 -> R_RESP.
  - R_RESP: rValid=1; rData and rResp held stable until rValid&&rReady, then IDLE.
- Latency from handshake cycle T:
  - Write: ramEn at T+1, bValid at T+2.
  - Read: ramEn at T+1, rValid at T+3.
- Timing of outputs:
  - ramEn is high for exactly one cycle per accepted in-range transaction and never in any other state.
  - ramAddr/ramWrite/ramStrb are don't-care when ramEn=0, but are registered outputs (no combinational path from AXI inputs).
- wStrb=0 on an in-range write: RAM enabled with no bytes written; OKAY response.
- An OOR write never modifies RAM; an OOR read never enables RAM.
- Ready signals are low in every non-IDLE state, so no new handshake is accepted while a response is pending.

Test Plan:
- Write 0xDEADBEEF, strb 0xF, to byte address 0x10, then read 0x10 -> ramEn at T+1 with ramAddr=4 for both accesses; bResp=00; rData=0xDEADBEEF, rResp=00, rValid at T+3.
- Write 0x11223344 strb 0xF, then 0xAABBCCDD strb 0x5, to address 0x8; read 0x8 -> rData=0x11BB33DD.
- Hold rReady=0 for 5 cycles after a read of 0x10 -> rValid and rData=0xDEADBEEF stable for all 5; arReady=0 throughout; a read completes the cycle rReady rises.
- After reset, AW+W and AR asserted together continuously -> grants alternate write, read, write, read; no handshake overlaps a pending response.
- Write to byte address 1<<(ADDR_W+2) (OOR) -> ramEn never asserts; bResp=10; a following read of address 0 returns its old value. OOR read -> rData=0, rResp=10, ramEn stays 0.
- awValid alone for 4 cycles -> awReady=0 until wValid rises. Separately, assert rst in R_CAPT -> next cycle all outputs 0, state IDLE, no rValid.

Source files
------------

// File: rtl/axil_ram_port.sv
// AXI4-Lite slave bridging single transactions onto one byte-enabled block-RAM port.
// Reads and writes share the port; simultaneous requests alternate round-robin.
module axil_ram_port #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int AXIL_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   awValid,
    output logic                   awReady,
    input  logic [AXIL_ADDR_W-1:0] awAddr,
    input  logic                   wValid,
    output logic                   wReady,
    input  logic [DATA_W-1:0]      wData,
    input  logic [DATA_W/8-1:0]    wStrb,
    output logic                   bValid,
    input  logic                   bReady,
    output logic [1:0]             bResp,
    input  logic                   arValid,
    output logic                   arReady,
    input  logic [AXIL_ADDR_W-1:0] arAddr,
    output logic                   rValid,
    input  logic                   rReady,
    output logic [DATA_W-1:0]      rData,
    output logic [1:0]             rResp,
    output logic [ADDR_W-1:0]      ramAddr,
    output logic [DATA_W-1:0]      ramWrite,
    output logic [DATA_W/8-1:0]    ramStrb,
    output logic                   ramEn,
    input  logic [DATA_W-1:0]      ramRead
);

    localparam int STRB_W = DATA_W / 8;
    localparam int S      = $clog2(STRB_W);
    localparam int TOP    = S + ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_ISSUE = 3'd1,
        W_RESP  = 3'd2,
        R_ISSUE = 3'd3,
        R_CAPT  = 3'd4,
        R_RESP  = 3'd5
    } state_e;

    // Any address bit above the RAM word range marks the access out of range.
    function automatic logic oor_f(input logic [AXIL_ADDR_W-1:0] a);
        return (a >> TOP) != {AXIL_ADDR_W{1'b0}};
    endfunction

    state_e              state_q, state_d;
    logic                grant_w_s, grant_r_s;
    logic                last_grant_write_q;
    logic                oor_q;
    logic                ram_en_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_write_q;
    logic [STRB_W-1:0]   ram_strb_q;
    logic [1:0]          b_resp_q;
    logic [DATA_W-1:0]   r_data_q;
    logic [1:0]          r_resp_q;
    logic                aw_oor_s, ar_oor_s;
    logic [ADDR_W-1:0]   aw_idx_s, ar_idx_s;

    assign aw_oor_s = oor_f(awAddr);
    assign ar_oor_s = oor_f(arAddr);
    assign aw_idx_s = awAddr[TOP-1:S];
    assign ar_idx_s = arAddr[TOP-1:S];

    // Round-robin grant between a complete AW+W pair and an AR, only while idle.
    always_comb begin
        grant_w_s = 1'b0;
        grant_r_s = 1'b0;
        if (state_q == IDLE) begin
            if (awValid && wValid && arValid) begin
                grant_w_s = !last_grant_write_q;
                grant_r_s = last_grant_write_q;
            end else begin
                grant_w_s = awValid && wValid;
                grant_r_s = arValid;
            end
        end else begin
            grant_w_s = 1'b0;
            grant_r_s = 1'b0;
        end
    end

    assign awReady = grant_w_s;
    assign wReady  = grant_w_s;
    assign arReady = grant_r_s;

    // Next-state logic for the single-transaction sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_w_s) begin
                    state_d = W_ISSUE;
                end else if (grant_r_s) begin
                    state_d = R_ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            W_ISSUE: state_d = W_RESP;
            W_RESP: begin
                if (bReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = W_RESP;
                end
            end
            R_ISSUE: state_d = R_CAPT;
            R_CAPT:  state_d = R_RESP;
            R_RESP: begin
                if (rReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = R_RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latching, RAM port drive and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_write_q <= 1'b0;
            oor_q              <= 1'b0;
            ram_en_q           <= 1'b0;
            ram_addr_q         <= {ADDR_W{1'b0}};
            ram_write_q        <= {DATA_W{1'b0}};
            ram_strb_q         <= {STRB_W{1'b0}};
            b_resp_q           <= 2'b00;
            r_data_q           <= {DATA_W{1'b0}};
            r_resp_q           <= 2'b00;
        end else begin
            ram_en_q <= 1'b0;
            if (grant_w_s) begin
                last_grant_write_q <= 1'b1;
                oor_q              <= aw_oor_s;
                ram_en_q           <= !aw_oor_s;
                ram_addr_q         <= aw_idx_s;
                ram_write_q        <= wData;
                ram_strb_q         <= wStrb;
                b_resp_q           <= aw_oor_s ? 2'b10 : 2'b00;
            end else if (grant_r_s) begin
                last_grant_write_q <= 1'b0;
                oor_q              <= ar_oor_s;
                ram_en_q           <= !ar_oor_s;
                ram_addr_q         <= ar_idx_s;
                ram_strb_q         <= {STRB_W{1'b0}};
            end else if (state_q == R_CAPT) begin
                r_data_q <= oor_q ? {DATA_W{1'b0}} : ramRead;
                r_resp_q <= oor_q ? 2'b10 : 2'b00;
            end
        end
    end

    assign bValid   = (state_q == W_RESP);
    assign rValid   = (state_q == R_RESP);
    assign bResp    = b_resp_q;
    assign rData    = r_data_q;
    assign rResp    = r_resp_q;
    assign ramEn    = ram_en_q;
    assign ramAddr  = ram_addr_q;
    assign ramWrite = ram_write_q;
    assign ramStrb  = ram_strb_q;

endmodule
